sum_uart_tx: RTL and testbench

SUM_UART_TX -- requirements
Module: sum_uart_tx

---
 rtl/sum_uart_tx_pkg.sv | 14 +
 rtl/sum_uart_tx_fifo.sv | 71 +++++++
 rtl/sum_uart_tx.sv | 115 +++++++++++
 tb/tb_sum_uart_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_tx_pkg.sv
// Shared types and default constants for the sum-value UART transmitter.
package sum_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/sum_uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty/count flags.
// A push is refused whenever full was set at the edge, even if a pop happens on that same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // Pushes are gated by the registered full flag and by reset; pops by the registered empty flag.
    assign do_push  = push && !full && !rst;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, occupancy and the flags derived from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage array; data needs no reset since pointers guard every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// Buffers sum bytes from the adder stage and serialises them as UART 8N1 frames.
// One IDLE cycle always separates frames, so back-to-back frames are 10*CLKS_PER_BIT+1 cycles apart.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int         CW        = $clog2(FIFO_DEPTH+1);
    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [7:0]    baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready and busy come straight from flops; the FSM pops only from IDLE with data present.
    assign in_ready = !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    // Frame sequencer: baud counter, bit index, shift register and the registered tx line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_data;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt    <= '0;
                        frames_sent <= frames_sent + 8'd1;
                        state       <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx with a byte scoreboard and a serial-line decoder.
module tb_sum_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sent_count = 0;
    logic [7:0] sb[$];
    int start_times[$];

    sum_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Serial decoder: samples each bit at its centre and pops the scoreboard per frame.
    initial begin : monitor
        bit         in_frame;
        int         off;
        int         j;
        logic [7:0] mb;
        logic [7:0] exp_b;
        in_frame = 1'b0;
        off = 0;
        mb = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    off = 0;
                    start_times.push_back(cyc);
                end
            end else begin
                off++;
                if (off % CPB == CPB / 2) begin
                    j = off / CPB;
                    if (j == 0) begin
                        checks++;
                        if (tx !== 1'b0) begin
                            failures++;
                            $display("FAIL start_bit tx=%b expected 0", tx);
                        end
                    end else if (j <= 8) begin
                        mb[j-1] = tx;
                    end else begin
                        in_frame = 1'b0;
                        checks++;
                        if (tx !== 1'b1) begin
                            failures++;
                            $display("FAIL stop_bit tx=%b expected 1", tx);
                        end
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_frame got=%02h expected none", mb);
                        end else begin
                            exp_b = sb.pop_front();
                            if (mb !== exp_b) begin
                                failures++;
                                $display("FAIL frame_data got=%02h expected %02h", mb, exp_b);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic push_byte(input logic [7:0] b, output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_data = b;
        while (in_ready !== 1'b1 && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL push_timeout in_ready=%b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(b);
        sent_count++;
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx tx=%b expected 1", tx); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b expected 1", in_ready); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected 0", busy); end
        checks++;
        if (frames_sent !== 8'd0) begin failures++; $display("FAIL reset_frames got=%0d expected 0", frames_sent); end
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        sent_count = 0;
    endtask

    task automatic test_idle();
        repeat (100) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_line tx=%b busy=%b in_ready=%b expected 1 0 1", tx, busy, in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int n;
        int s;
        start_times.delete();
        push_byte(8'h3C, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        in_valid = 1'b0;
        n = 0;
        while (start_times.size() == 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (start_times.size() == 0) begin
            failures++;
            $display("FAIL midreset_no_start frames=%0d expected 1", start_times.size());
            return;
        end
        s = start_times[0];
        n = 0;
        while (cyc < s + 17 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        sb.delete();
        sent_count = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx tx=%b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b expected 0", busy); end
        checks++;
        if (frames_sent !== 8'd0) begin failures++; $display("FAIL midreset_frames got=%0d expected 0", frames_sent); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b expected 1", in_ready); end
        repeat (100) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet tx=%b busy=%b expected 1 0", tx, busy);
            end
        end
        checks++;
        if (start_times.size() != 1) begin
            failures++;
            $display("FAIL midreset_extra_frames got=%0d expected 1", start_times.size());
        end
    endtask

    task automatic test_single();
        start_times.delete();
        in_valid = 1'b1;
        in_data = 8'hA5;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b expected 1", in_ready); end
        @(posedge clk);
        sb.push_back(8'hA5);
        sent_count++;
        #1;
        in_valid = 1'b0;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL latency_early tx=%b expected 1", tx); end
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL latency_start tx=%b expected 0", tx); end
        wait_idle();
        checks++;
        if (frames_sent !== 8'(sent_count)) begin
            failures++;
            $display("FAIL single_frames got=%0d expected %0d", frames_sent, 8'(sent_count));
        end
        checks++;
        if (sb.size() != 0 || start_times.size() != 1) begin
            failures++;
            $display("FAIL single_drain pending=%0d frames=%0d expected 0 1", sb.size(), start_times.size());
        end
    endtask

    task automatic test_fill();
        int w;
        int accept_cyc;
        logic [7:0] b;
        start_times.delete();
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            push_byte(b, w);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_full in_ready=%b expected 0", in_ready); end
        push_byte(8'h06, w);
        accept_cyc = cyc;
        in_valid = 1'b0;
        checks++;
        if (w == 0) begin failures++; $display("FAIL fill_holdoff waited=%0d expected >0", w); end
        checks++;
        if (start_times.size() < 2) begin
            failures++;
            $display("FAIL full_pop_edge frames=%0d expected >=2", start_times.size());
        end else if (accept_cyc != start_times[1] + 1) begin
            failures++;
            $display("FAIL full_pop_edge accept=%0d expected %0d", accept_cyc, start_times[1] + 1);
        end
        wait_idle();
        checks++;
        if (start_times.size() != 6) begin
            failures++;
            $display("FAIL fill_count frames=%0d expected 6", start_times.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (start_times[i] - start_times[i-1] != 10 * CPB + 1) begin
                    failures++;
                    $display("FAIL frame_period got=%0d expected %0d", start_times[i] - start_times[i-1], 10 * CPB + 1);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL fill_pending got=%0d expected 0", sb.size()); end
        checks++;
        if (frames_sent !== 8'(sent_count)) begin
            failures++;
            $display("FAIL fill_frames got=%0d expected %0d", frames_sent, 8'(sent_count));
        end
    endtask

    task automatic test_wrap();
        int w;
        logic [7:0] b;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        start_times.delete();
        sent_count = 0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            push_byte(b, w);
        end
        in_valid = 1'b0;
        wait_idle();
        checks++;
        if (frames_sent !== 8'd0) begin failures++; $display("FAIL wrap_256 got=%0d expected 0", frames_sent); end
        push_byte(8'h5A, w);
        in_valid = 1'b0;
        wait_idle();
        checks++;
        if (frames_sent !== 8'd1) begin failures++; $display("FAIL wrap_257 got=%0d expected 1", frames_sent); end
        checks++;
        if (sb.size() != 0 || start_times.size() != 257) begin
            failures++;
            $display("FAIL wrap_drain pending=%0d frames=%0d expected 0 257", sb.size(), start_times.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_reset_mid();
        test_single();
        test_fill();
        test_wrap();
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
